shift_pipe_arbiter: RTL
=======================

Name: shift_pipe_arbiter

Overview:
Arbitrates two requesters for one shared serial shift pipeline, a DEPTH-stage chain of non-blocking registers. The granted requester's WIDTH-bit word is serialized LSB-first into the chain. The delayed serial stream is deserialized back into a word and returned with a done pulse and the requester id. It is the sequencing and sharing front end for the team's shift-register datapaths.

Parameters:
WIDTH, 8, bits per word; at least 2.
DEPTH, 2, pipeline stages between serial in and serial out; at least 1.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  requester 0 request; held high until ack0
data0  input  WIDTH  requester 0 word; held stable while req0 is high
req1  input  1  requester 1 request; held high until ack1
data1  input  WIDTH  requester 1 word; held stable while req1 is high
ack0  output  1  one-cycle pulse: requester 0 word accepted
ack1  output  1  one-cycle pulse: requester 1 word accepted
busy  output  1  high in every state except IDLE
sout  output  1  last pipeline stage; debug observation only
done  output  1  one-cycle pulse: rdata and rid are valid
rdata  output  WIDTH  deserialized word; holds its value until the next done
rid  output  1  requester that owns rdata (0 or 1)

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all pipeline stages 0.
  - ack0, ack1, busy, done, rdata, rid, sout all 0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset asserted mid-transaction aborts it: no done and no ack are issued, and the word is dropped.
- Pipeline: stage0 <= sin; stage[i] <= stage[i-1]; sout = stage[DEPTH-1]. sin is the shift-register LSB in SHIFT and 0 in every other state.
- State machine IDLE -> SHIFT -> FLUSH -> DONE -> IDLE.
- IDLE:
  - Edge with only req0 high: grant 0.
  - Edge with only req1 high: grant 1.
  - Edge with both high: grant the requester that is not last_grant.
  - On a grant:
    - Load the granted data into the shift register.
    - Set the owner register and last_grant to the granted id.
    - Set the matching ack for the next cycle only.
    - Go to SHIFT.
  - No request: remain in IDLE.
- SHIFT: exactly WIDTH cycles.
  - Each cycle drives the shift-register LSB into sin and shifts right.
  - A bit counter runs 0..WIDTH-1; go to FLUSH when it reaches WIDTH-1.
- FLUSH: exactly DEPTH cycles with sin=0; then go to DONE.
- Capture: a counter from the first SHIFT cycle shifts sout into the MSB of the deserializer on the edges ending cycles DEPTH+1 .. DEPTH+WIDTH (first SHIFT cycle = cycle 1). After the last capture, bit k of the result equals bit k of the accepted word.
- DONE: one cycle.
  - done=1, rdata = deserializer, rid = owner.
  - Next edge returns to IDLE. A new request is sampled in IDLE, never in DONE.
- Timing: done is high in cycle WIDTH+DEPTH+1 after the accept edge. Turnaround is WIDTH+DEPTH+2 cycles per word: accept edge, SHIFT, FLUSH, DONE, then at least one IDLE cycle.
- Requests while busy are ignored; they remain pending, and requesters keep req and data stable.
- If req stays high after its ack, it is a new request at the next IDLE edge.
- Round-robin alternation holds for any sustained dual request; no starvation.
- Counter widths are ceil(log2(WIDTH+DEPTH+1)). Counters must not wrap inside a transaction.

Test Plan:
- Reset default values: assert rst asynchronously mid-cycle -> all outputs 0 immediately without a clock edge; hold rst with req0=1 -> no ack0.
- Single requester (WIDTH=8, DEPTH=2): req0=1, data0=8'hA5 sampled at edge E0.
  - ack0=1 in cycle 1 only; busy=1 for cycles 1..11.
  - sout shows 1,0,1,0,0,1,0,1 in cycles 3..10.
  - done=1 in cycle 11 with rdata=8'hA5, rid=0.
- Tie and fairness: req0 and req1 held high, data0=8'h3C, data1=8'hC3.
  - First done: rid=0, rdata=8'h3C.
  - Second done: rid=1, rdata=8'hC3.
  - Third done: rid=0 again.
- Request while busy: req1=1, data1=8'hFF raised during SHIFT of a req0 transaction -> no ack1 until IDLE; ack1 arrives one cycle after the IDLE accept edge; done then gives rdata=8'hFF, rid=1.
- Abort: pulse rst for one cycle during FLUSH -> no done; state back to IDLE; the next req1 with data1=8'h81 completes normally with rdata=8'h81.
- Parameter sweep: WIDTH=4, DEPTH=1 and WIDTH=16, DEPTH=5 with random words -> rdata equals the accepted word; done exactly WIDTH+DEPTH+1 cycles after the accept edge.

Source files
------------

// File: rtl/shift_pipe_arbiter_if.sv
// Requester/response bundle for shift_pipe_arbiter: two request channels,
// their acks, and the deserialized result with its owner id.
interface shift_pipe_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic             busy;
  logic             sout;
  logic             done;
  logic [WIDTH-1:0] rdata;
  logic             rid;

  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, busy, sout, done, rdata, rid
  );

  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, busy, sout, done, rdata, rid
  );
endinterface

// File: rtl/shift_pipe_arbiter.sv
// Round-robin arbiter sharing a DEPTH-stage serial pipeline between two
// requesters; words go in LSB-first and are reassembled at the far end.
module shift_pipe_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_pipe_arbiter_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-2:0] desr_q;
  logic [WIDTH-1:0] desr_next;
  logic [WIDTH-1:0] rdata_q;
  logic [CW-1:0]    cnt_q;
  logic [DEPTH-1:0] pipe_q;
  logic             last_grant_q, owner_q, rid_q, ack0_q, ack1_q;
  logic             grant, gnt_id, sin, capture, finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    sin     = 1'b0;
    // On a tie the requester that did not win last time gets the pipe.
    gnt_id  = bus.req1 & (~bus.req0 | ~last_grant_q);
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sin = shreg_q[0];
        if (cnt_q == LAST_SHIFT) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt_q == LAST_FLUSH) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter spans SHIFT and FLUSH; capture starts once the first bit
  // has crossed all DEPTH stages and ends on the last FLUSH edge.
  assign capture   = ((state_q == SHIFT) || (state_q == FLUSH)) && (cnt_q >= CAP_FIRST);
  assign finish    = (state_q == FLUSH) && (cnt_q == LAST_FLUSH);
  assign desr_next = {pipe_q[DEPTH-1], desr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q      <= '0;
      desr_q       <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      pipe_q       <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rid_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      ack0_q    <= grant & ~gnt_id;
      ack1_q    <= grant & gnt_id;
      pipe_q[0] <= sin;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];

      if (grant) begin
        shreg_q      <= gnt_id ? bus.data1 : bus.data0;
        owner_q      <= gnt_id;
        last_grant_q <= gnt_id;
        cnt_q        <= '0;
      end else if (state_q == SHIFT) begin
        shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
        cnt_q   <= cnt_q + 1'b1;
      end else if (state_q == FLUSH) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (capture) desr_q <= desr_next[WIDTH-1:1];
      if (finish) begin
        rdata_q <= desr_next;
        rid_q   <= owner_q;
      end
    end
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.sout  = pipe_q[DEPTH-1];
  assign bus.done  = (state_q == DONE);
  assign bus.rdata = rdata_q;
  assign bus.rid   = rid_q;

endmodule
